// File: rtl/fpadd_sequencer.sv
// fpadd_sequencer
//
// Shares one single-precision FP add datapath between two requesters.
// An operand pair is accepted in IDLE, aligned, added, normalized
// (iteratively, up to NORM_STEP left shifts per cycle) and returned on a
// single response port that holds its result until the consumer takes it.
// The sum is truncated; inf/NaN inputs are treated as ordinary values.
//
// Parameters:
//   NORM_STEP  max left-shift positions per NORM cycle (1, 2 or 4)
//
// Build option:
//   FPADD_SEQ_RR_EN  defined   -> round-robin arbitration between requesters
//                    undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   req0_valid/ready/a/b        requester 0 operand handshake
//   req1_valid/ready/a/b        requester 1 operand handshake
//   resp_valid/ready            result handshake
//   resp_id                     requester that owns resp_sum
//   resp_sum                    A+B, IEEE-754 single precision
//   busy                        high whenever not IDLE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | arbitrate, accept one request
// ALIGN | unpack operands, right-shift the smaller-exponent mantissa
// ADD   | add or subtract aligned mantissas, pick result sign
// NORM  | carry/zero/normalized checks, else left-shift and stay
// DONE  | present result until resp_ready

module fpadd_sequencer #(
    parameter int NORM_STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_sum,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} stateT;

    stateT       state, nextState;
    logic        grant, accept, lastGrant, idleLive;
    logic [31:0] opA, opB;
    logic [23:0] alignA, alignB;
    logic [24:0] sumR;
    logic [8:0]  expR;
    logic        signR;

    logic [7:0]  expA, expB, expBig, expDiff;
    logic [23:0] mantA, mantB, shA, shB;
    logic [24:0] addSum;
    logic        addSign;
    logic [4:0]  lzCount, shiftAmt;
    logic [8:0]  expInc;
    logic        normFinish;

    // Grant selection; ready is gated by valid so only a real requester sees it.
`ifdef FPADD_SEQ_RR_EN
    always_comb begin
        if (req0_valid && req1_valid) grant = ~lastGrant;
        else                          grant = ~req0_valid;
    end
`else
    logic unusedLastGrant;
    assign unusedLastGrant = lastGrant;
    always_comb grant = ~req0_valid;
`endif

    assign idleLive   = (state == IDLE) && !reset;
    assign req0_ready = idleLive && req0_valid && !grant;
    assign req1_ready = idleLive && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    // Unpack and align. Exponent 0 means a true zero (no hidden bit).
    always_comb begin
        expA  = opA[30:23];
        expB  = opB[30:23];
        mantA = (expA == 8'd0) ? 24'd0 : {1'b1, opA[22:0]};
        mantB = (expB == 8'd0) ? 24'd0 : {1'b1, opB[22:0]};
        if (expA >= expB) begin
            expBig  = expA;
            expDiff = expA - expB;
            shA     = mantA;
            shB     = (expDiff >= 8'd24) ? 24'd0 : (mantB >> expDiff);
        end else begin
            expBig  = expB;
            expDiff = expB - expA;
            shA     = (expDiff >= 8'd24) ? 24'd0 : (mantA >> expDiff);
            shB     = mantB;
        end
    end

    always_comb begin
        addSum  = 25'd0;
        addSign = 1'b0;
        if (opA[31] == opB[31]) begin
            addSum  = {1'b0, alignA} + {1'b0, alignB};
            addSign = opA[31];
        end else if (alignA > alignB) begin
            addSum  = {1'b0, alignA - alignB};
            addSign = opA[31];
        end else if (alignB > alignA) begin
            addSum  = {1'b0, alignB - alignA};
            addSign = opB[31];
        end
    end

    // Leading zeros counted from bit 23; highest set bit wins.
    always_comb begin
        lzCount = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (sumR[i]) lzCount = 5'(23 - i);
        end
        shiftAmt   = (lzCount < 5'(NORM_STEP)) ? lzCount : 5'(NORM_STEP);
        expInc     = expR + 9'd1;
        normFinish = (sumR == 25'd0) || sumR[24] || sumR[23] ||
                     ({4'd0, shiftAmt} >= expR);
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = ALIGN;
            ALIGN:   nextState = ADD;
            ADD:     nextState = NORM;
            NORM:    if (normFinish) nextState = DONE;
            DONE:    if (resp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opA        <= 32'd0;
            opB        <= 32'd0;
            lastGrant  <= 1'b1;
            alignA     <= 24'd0;
            alignB     <= 24'd0;
            expR       <= 9'd0;
            sumR       <= 25'd0;
            signR      <= 1'b0;
            resp_id    <= 1'b0;
            resp_sum   <= 32'd0;
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= (nextState == DONE);
            case (state)
                IDLE: if (accept) begin
                    opA       <= grant ? req1_a : req0_a;
                    opB       <= grant ? req1_b : req0_b;
                    resp_id   <= grant;
                    lastGrant <= grant;
                end
                ALIGN: begin
                    alignA <= shA;
                    alignB <= shB;
                    expR   <= {1'b0, expBig};
                end
                ADD: begin
                    sumR  <= addSum;
                    signR <= addSign;
                end
                NORM: begin
                    if (sumR == 25'd0) begin
                        resp_sum <= 32'd0;
                    end else if (sumR[24]) begin
                        if (expInc >= 9'd255) resp_sum <= {signR, 8'hFF, 23'd0};
                        else                  resp_sum <= {signR, expInc[7:0], sumR[23:1]};
                    end else if (sumR[23]) begin
                        resp_sum <= {signR, expR[7:0], sumR[22:0]};
                    end else if ({4'd0, shiftAmt} >= expR) begin
                        resp_sum <= {signR, 31'd0};
                    end else begin
                        sumR <= sumR << shiftAmt;
                        expR <= expR - {4'd0, shiftAmt};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_sequencer.sv
// Directed bench for fpadd_sequencer: hand-computed sums, latency,
// arbitration order, backpressure hold and asynchronous reset.

module tb_fpadd_sequencer;

    localparam int NS = 1;
    localparam int LAT_SHIFT = (NS == 1) ? 26 : (NS == 2) ? 15 : 9;
`ifdef FPADD_SEQ_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, busy;
    logic [31:0] resp_sum;

    int checks = 0;
    int errors = 0;

    fpadd_sequencer #(.NORM_STEP(NS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic runOp(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expSum, input int expLat, input string tag);
        int lat;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        checkEq({tag, "_ready"}, id ? req1_ready : req0_ready, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkEq({tag, "_busy"}, busy, 32'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid && lat < 100);
        checkEq({tag, "_lat"}, lat, expLat);
        checkEq({tag, "_sum"}, resp_sum, expSum);
        checkEq({tag, "_id"}, resp_id, id);
        @(posedge clk); #1;
        checkEq({tag, "_drain"}, resp_valid, 32'd0);
    endtask

    initial begin
        int n;
        logic wantId;

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
        resp_ready = 1'b1;
        #2 req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst_valid", resp_valid, 32'd0);
        checkEq("rst_busy", busy, 32'd0);
        checkEq("rst_sum", resp_sum, 32'd0);
        checkEq("rst_id", resp_id, 32'd0);
        checkEq("rst_ready0", req0_ready, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk) reset = 1'b0;

        runOp(1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 3, "add12");
        runOp(1'b1, 32'h3F800000, 32'hBF800000, 32'h00000000, 3, "cancel");
        runOp(1'b0, 32'h3F800001, 32'hBF800000, 32'h34000000, LAT_SHIFT, "norm23");
        runOp(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3, "ovf");
        runOp(1'b0, 32'h3F800000, 32'h00000000, 32'h3F800000, 3, "addzero");
        runOp(1'b1, 32'h40000000, 32'hC0400000, 32'hBF800000, 4, "sub1");
        runOp(1'b0, 32'h80800001, 32'h00800000, 32'h80000000, 3, "uflow");

        // Arbitration with both requesters continuously valid.
        @(negedge clk) reset = 1'b1;
        @(negedge clk) begin
            reset = 1'b0;
            req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
            req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
        end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!resp_valid && n < 50);
            wantId = RR ? ((k % 2) == 1) : 1'b0;
            checkEq("arb_id", resp_id, wantId);
            checkEq("arb_sum", resp_sum, wantId ? 32'h40000000 : 32'h40400000);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure hold, then reset while a result is pending.
        @(negedge clk) begin
            resp_ready = 1'b0;
            req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        end
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!resp_valid && n < 50);
        for (int k = 0; k < 10; k++) begin
            checkEq("hold_valid", resp_valid, 32'd1);
            checkEq("hold_sum", resp_sum, 32'h40400000);
            checkEq("hold_id", resp_id, 32'd0);
            checkEq("hold_rdy0", req0_ready, 32'd0);
            checkEq("hold_rdy1", req1_ready, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk) reset = 1'b1;
        #1;
        checkEq("arst_valid", resp_valid, 32'd0);
        checkEq("arst_busy", busy, 32'd0);
        checkEq("arst_rdy0", req0_ready, 32'd0);
        @(negedge clk) reset = 1'b0;
        #1;
        checkEq("post_rdy0", req0_ready, 32'd1);
        checkEq("post_rdy1", req1_ready, 32'd0);
        resp_ready = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!resp_valid && n < 50);
        checkEq("post_id", resp_id, 32'd0);
        checkEq("post_sum", resp_sum, 32'h40400000);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
